// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter for the MAR/MDR system bus.
//
// The CPU queues characters into a DEPTH-entry transmit FIFO, programs a baud
// divider and reads a status word. The serializer runs on the system clock.
// Each bit lasts (div+1) << DIV_SHIFT clocks. Frames are 8N1, or 8E1 when
// parity is enabled.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clock        system clock
//   n_reset      asynchronous active-low reset
//   MDR_bus      allows the block to drive sysbus with mdr
//   CS           chip select for status / divider reads
//   R_NW         1 = read
//   load_MAR     latch the address field of sysbus into mar
//   load_MDR     write sysbus to the addressed register (FIFO or divider)
//   uart_tx_pin  serial output, idle high
//   sysbus       shared bidirectional system bus
//
// Status word: bit0 full, bit1 empty, bit2 busy, bit3 overflow,
//              bits[WORD_W-1:4] FIFO count.

module uart_tx_fifo #(
  parameter int WORD_W      = 8,
  parameter int OP_W        = 3,
  parameter int DEPTH       = 8,
  parameter int DATA_ADDR   = 26,
  parameter int STATUS_ADDR = 27,
  parameter int DIV_ADDR    = 28,
  parameter int DIV_SHIFT   = 4,
  parameter int DIV_RESET   = 255
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              MDR_bus,
  input  logic              CS,
  input  logic              R_NW,
  input  logic              load_MAR,
  input  logic              load_MDR,
  output logic              uart_tx_pin,
  inout  wire  [WORD_W-1:0] sysbus
);

  localparam int AW     = WORD_W - OP_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = WORD_W + DIV_SHIFT + 1;
  localparam int BW     = $clog2(WORD_W) + 1;
  localparam int CNT_FW = WORD_W - 4;

  localparam logic [AW-1:0]     DATA_A   = AW'(DATA_ADDR);
  localparam logic [AW-1:0]     STATUS_A = AW'(STATUS_ADDR);
  localparam logic [AW-1:0]     DIV_A    = AW'(DIV_ADDR);
  localparam logic [PW:0]       DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [WORD_W-1:0] DIV_INIT = WORD_W'(DIV_RESET);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;

  function automatic logic even_parity(input logic [WORD_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Registers
  logic [2:0]        state_q,  state_d;
  logic              pin_q,    pin_d;
  logic [WORD_W-1:0] shift_q,  shift_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [WORD_W-1:0] div_q,    div_d;
  logic [AW-1:0]     mar_q,    mar_d;
  logic [WORD_W-1:0] mdr_q,    mdr_d;
  logic              ovf_q,    ovf_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q,  count_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q,    par_d;
`endif
  logic [WORD_W-1:0] mem_q [DEPTH];

  // Combinational helpers
  logic              full_s, empty_s, busy_s, bit_end_s;
  logic              pop_s, push_req_s, push_s, drop_s, drive_s;
  logic [CW-1:0]     bit_len_m1_s;
  logic [WORD_W-1:0] head_s, status_s;

  assign full_s       = (count_q == DEPTH_C);
  assign empty_s      = (count_q == (PW+1)'(0));
  assign busy_s       = (state_q != S_IDLE);
  assign bit_end_s    = (cnt_q == CW'(0));
  assign bit_len_m1_s = ((CW'(div_q) + CW'(1)) << DIV_SHIFT) - CW'(1);
  assign head_s       = mem_q[rd_ptr_q];
  assign status_s     = {CNT_FW'(count_q), ovf_q, busy_s, empty_s, full_s};

  // The serializer takes a new character either from idle or straight out
  // of STOP, which is what makes back-to-back frames gap-free.
  assign pop_s      = !empty_s && ((state_q == S_IDLE) ||
                                   ((state_q == S_STOP) && bit_end_s));
  assign push_req_s = !load_MAR && load_MDR && (mar_q == DATA_A);
  assign push_s     = push_req_s && (!full_s || pop_s);
  assign drop_s     = push_req_s && full_s && !pop_s;

  assign drive_s     = MDR_bus && ((mar_q == STATUS_A) || (mar_q == DIV_A));
  assign sysbus      = drive_s ? mdr_q : {WORD_W{1'bz}};
  assign uart_tx_pin = pin_q;

  // Next-state logic: bus decode, FIFO bookkeeping and serializer FSM.
  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    // Bus decode, highest priority first.
    if (load_MAR) begin
      mar_d = sysbus[AW-1:0];
    end else if (load_MDR) begin
      if (mar_q == DIV_A) begin
        div_d = sysbus;
      end else begin
        div_d = div_q;
      end
    end else if (CS && R_NW) begin
      if (mar_q == STATUS_A) begin
        mdr_d = status_s;
        ovf_d = 1'b0;
      end else if (mar_q == DIV_A) begin
        mdr_d = div_q;
      end else begin
        mdr_d = mdr_q;
      end
    end else begin
      mar_d = mar_q;
    end

    // A dropped write sets overflow even if a status read clears it.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // Serializer. The bit counter reloads from div at every bit boundary,
    // so a divider write only affects the following bit.
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          state_d = S_START;
          pin_d   = 1'b0;
          shift_d = head_s;
          cnt_d   = bit_len_m1_s;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(head_s);
`endif
        end else begin
          pin_d   = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          pin_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = BW'(0);
          cnt_d     = bit_len_m1_s;
        end else begin
          cnt_d     = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = bit_len_m1_s;
          if (bit_idx_q == BW'(WORD_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            pin_d   = par_q;
`else
            state_d = S_STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            pin_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          pin_d   = 1'b1;
          cnt_d   = bit_len_m1_s;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          if (!empty_s) begin
            state_d = S_START;
            pin_d   = 1'b0;
            shift_d = head_s;
            cnt_d   = bit_len_m1_s;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(head_s);
`endif
          end else begin
            state_d = S_IDLE;
            pin_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        pin_d   = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      pin_q     <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      div_q     <= DIV_INIT;
      mar_q     <= '0;
      mdr_q     <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= sysbus;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic MDR_bus = 1'b0, CS = 1'b0, R_NW = 1'b0, load_MAR = 1'b0, load_MDR = 1'b0;
  logic uart_tx_pin;
  logic [7:0] tb_bus = 8'h00;
  logic tb_drv = 1'b0;
  wire [7:0] sysbus;

  assign sysbus = tb_drv ? tb_bus : 8'bz;

  always #5 clock = ~clock;

  uart_tx_fifo dut (
    .clock(clock), .n_reset(n_reset), .MDR_bus(MDR_bus), .CS(CS), .R_NW(R_NW),
    .load_MAR(load_MAR), .load_MDR(load_MDR), .uart_tx_pin(uart_tx_pin),
    .sysbus(sysbus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0]  m_mar;
  logic [7:0]  m_div, m_mdr;
  bit          m_ovf, m_busy, m_pin, m_popped;
  logic [7:0]  m_q[$];
  bit   [10:0] m_bits;
  int          m_nbits, m_bit, m_left, m_pre;
  logic [7:0]  m_st;

  function automatic int period(input logic [7:0] d);
    return (int'(d) + 1) * 16;
  endfunction

  task automatic m_reset();
    m_mar = 5'd0; m_div = 8'd255; m_mdr = 8'd0; m_ovf = 1'b0;
    m_busy = 1'b0; m_pin = 1'b1; m_q.delete();
    m_nbits = 0; m_bit = 0; m_left = 0; m_bits = 11'd0;
  endtask

  // Builds the frame bit list: start, data LSB first, [parity], stop.
  task automatic m_start(input logic [7:0] d);
    m_bits = 11'd0;
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    m_bits[9] = ^d;
    m_bits[10] = 1'b1;
    m_nbits = 11;
`else
    m_bits[9] = 1'b1;
    m_nbits = 10;
`endif
    m_bit = 0;
    m_left = period(m_div);
    m_pin = 1'b0;
    m_busy = 1'b1;
  endtask

  task automatic m_step();
    m_pre = m_q.size();
    m_st = {4'(m_pre), m_ovf, m_busy, (m_pre == 0), (m_pre == DEPTH)};
    m_popped = 1'b0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_bit++;
        if (m_bit == m_nbits) begin
          if (m_pre != 0) begin
            m_start(m_q.pop_front());
            m_popped = 1'b1;
          end else begin
            m_busy = 1'b0;
            m_pin = 1'b1;
          end
        end else begin
          m_left = period(m_div);
          m_pin = m_bits[m_bit];
        end
      end
    end else if (m_pre != 0) begin
      m_start(m_q.pop_front());
      m_popped = 1'b1;
    end
    if (load_MAR) m_mar = sysbus[4:0];
    else if (load_MDR) begin
      if (m_mar == 5'd26) begin
        if (m_pre < DEPTH || m_popped) m_q.push_back(sysbus);
        else m_ovf = 1'b1;
      end else if (m_mar == 5'd28) m_div = sysbus;
    end else if (CS && R_NW) begin
      if (m_mar == 5'd27) begin m_mdr = m_st; m_ovf = 1'b0; end
      else if (m_mar == 5'd28) m_mdr = m_div;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge n_reset);
      if (!n_reset) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare of the serial line against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (n_reset) begin
        total++;
        if (uart_tx_pin !== m_pin) begin
          bad++;
          $display("FAIL pin_model: got %b expected %b at %0t", uart_tx_pin, m_pin, $time);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_mar(input logic [7:0] a);
    tb_bus = a; tb_drv = 1'b1; load_MAR = 1'b1;
    tick();
    load_MAR = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] d);
    tb_bus = d; tb_drv = 1'b1; load_MDR = 1'b1;
    tick();
    load_MDR = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic read_reg(input string name, input logic [7:0] a, input logic [7:0] lit);
    logic [7:0] v;
    set_mar(a);
    CS = 1'b1; R_NW = 1'b1;
    tick();
    CS = 1'b0; R_NW = 1'b0; MDR_bus = 1'b1;
    #1 v = sysbus;
    chk({name, "_model"}, {24'h0, v}, {24'h0, m_mdr});
    chk({name, "_lit"}, {24'h0, v}, {24'h0, lit});
    tick();
    MDR_bus = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!m_busy && m_q.size() == 0) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_timeout: got busy expected idle within %0d cycles", limit);
    end
  endtask

  logic [9:0]  frame55;
  logic [7:0]  ovf_bytes [10];
  logic [31:0] zz;

  initial begin
    frame55 = {1'b1, 8'h55, 1'b0};
    ovf_bytes = '{8'h00, 8'hFF, 8'h81, 8'h42, 8'h3C, 8'hA5, 8'h5A, 8'h01, 8'h99, 8'h77};
    zz = {24'h0, 8'bz};

    repeat (3) tick();
    chk("reset_pin", {31'h0, uart_tx_pin}, 32'h1);
    n_reset = 1'b1;
    tick();

    // Reset values and bus tri-state behaviour.
    read_reg("div_reset", 8'd28, 8'hFF);
    #1 chk("bus_z_mdrbus0", {24'h0, sysbus}, zz);
    read_reg("status_reset", 8'd27, 8'h02);
    set_mar(8'd26);
    MDR_bus = 1'b1;
    #1 chk("bus_z_mar26", {24'h0, sysbus}, zz);
    tick();
    MDR_bus = 1'b0;

    // 0x55 with div=0: 16-clock bits.
    set_mar(8'd28); write_data(8'd0);
    set_mar(8'd26); write_data(8'h55);
    chk("pin_before_pop", {31'h0, uart_tx_pin}, 32'h1);
    tick();
    chk("pin_start_edge", {31'h0, uart_tx_pin}, 32'h0);
    repeat (8) tick();
    for (int k = 0; k < 10; k++) begin
      chk("frame55_bit", {31'h0, uart_tx_pin}, {31'h0, frame55[k]});
      if (k < 9) repeat (16) tick();
    end
    read_reg("status_in_stop", 8'd27, 8'h06);
    repeat (10) tick();
    read_reg("status_after_frame", 8'd27, 8'h02);

    // Ten consecutive writes: fill, overflow, sticky clear on read.
    set_mar(8'd26);
    for (int i = 0; i < 10; i++) write_data(ovf_bytes[i]);
    read_reg("status_overflow", 8'd27, 8'h8D);
    read_reg("status_ovf_cleared", 8'd27, 8'h85);
    wait_idle(2000);
    repeat (5) tick();

    // Back-to-back 0x00 then 0xFF: no idle gap.
    set_mar(8'd26);
    write_data(8'h00);
    write_data(8'hFF);
    repeat (159) tick();
    chk("b2b_last_stop", {31'h0, uart_tx_pin}, 32'h1);
    tick();
    chk("b2b_next_start", {31'h0, uart_tx_pin}, 32'h0);
    wait_idle(400);
    repeat (5) tick();

    // Divider change mid start bit takes effect at the next bit.
    set_mar(8'd26);
    write_data(8'hA5);
    set_mar(8'd28);
    write_data(8'd1);
    repeat (14) tick();
    chk("div_start_last", {31'h0, uart_tx_pin}, 32'h0);
    tick();
    chk("div_bit0_first", {31'h0, uart_tx_pin}, 32'h1);
    repeat (31) tick();
    chk("div_bit0_last", {31'h0, uart_tx_pin}, 32'h1);
    tick();
    chk("div_bit1_first", {31'h0, uart_tx_pin}, 32'h0);
    set_mar(8'd28); write_data(8'd0);
    wait_idle(1000);
    repeat (5) tick();

    // Reset in the middle of the data bits, with a byte still queued.
    set_mar(8'd26);
    write_data(8'h00);
    write_data(8'h3C);
    repeat (40) tick();
    chk("pre_reset_pin", {31'h0, uart_tx_pin}, 32'h0);
    #2 n_reset = 1'b0;
    #1 chk("async_reset_pin", {31'h0, uart_tx_pin}, 32'h1);
    tick();
    n_reset = 1'b1;
    tick();
    read_reg("status_post_reset", 8'd27, 8'h02);
    read_reg("div_post_reset", 8'd28, 8'hFF);

`ifdef UART_TX_PARITY_EN
    set_mar(8'd28); write_data(8'd0);
    set_mar(8'd26); write_data(8'h07);
    tick();
    repeat (152) tick();
    chk("parity_bit", {31'h0, uart_tx_pin}, 32'h1);
    repeat (16) tick();
    chk("parity_stop", {31'h0, uart_tx_pin}, 32'h1);
    wait_idle(400);
`endif

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
